// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: serial double-dabble binary-to-BCD converter feeding a
// multiplexed 4-digit display scanner with leading-zero blanking.
module display_scan_ctrl #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        load,
    input  logic [13:0] value,
    output logic        ready,
    output logic        ovf,
    output logic [3:0]  an_n,
    output logic [3:0]  digit_code
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;
    logic [0:0]  state_q, state_d;
    logic [13:0] shift_q, shift_d;
    logic [15:0] bcd_q, bcd_d, bcd_adj;
    logic [3:0]  cnt_q, cnt_d;
    logic        big_q, big_d;
    logic [15:0] disp_q, disp_d;
    logic        ovf_q, ovf_d;
    logic [15:0] pre_q, pre_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  blank;
    logic        wrap;
    for (genvar g = 0; g < 4; g++) begin : g_adj
        assign bcd_adj[4*g +: 4] = bcd_q[4*g +: 4] >= 4'd5 ? bcd_q[4*g +: 4] + 4'd3 : bcd_q[4*g +: 4];
    end
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        big_d   = big_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE) begin
            if (load) begin
                state_d = CONV;
                shift_d = value;
                bcd_d   = '0;
                cnt_d   = '0;
                big_d   = value > 14'd9999;
            end
        end else begin
            {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd13) begin
                state_d = IDLE;
                ovf_d   = big_q;
                disp_d  = big_q ? 16'hFFFF : bcd_d;
            end
        end
    end
    assign wrap  = pre_q == 16'(SCAN_DIV - 1);
    assign pre_d = wrap ? 16'd0 : pre_q + 16'd1;
    assign idx_d = wrap ? idx_q + 2'd1 : idx_q;
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            big_q   <= 1'b0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            big_q   <= big_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
        end
    end
    // A digit is blank when it and every more significant digit are zero; digit 0 always shows.
    assign blank[3] = disp_q[15:12] == 4'd0;
    assign blank[2] = blank[3] && disp_q[11:8] == 4'd0;
    assign blank[1] = blank[2] && disp_q[7:4] == 4'd0;
    assign blank[0] = 1'b0;
    assign ready      = state_q == IDLE;
    assign ovf        = ovf_q;
    assign an_n       = ~(4'b0001 << idx_q);
    assign digit_code = blank[idx_q] ? 4'hF : disp_q[4*idx_q +: 4];
endmodule
